// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared definitions for the RV32I control sequencer: state codes, opcodes,
// immediate-type, PC-source and write-back select codes, and the decode record.
package cpu_ctrl_fsm_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Table order defines the bit positions of the decoder's match vector.
  localparam int OPC_NUM = 9;
  localparam int IX_LUI    = 0;
  localparam int IX_AUIPC  = 1;
  localparam int IX_JAL    = 2;
  localparam int IX_JALR   = 3;
  localparam int IX_BRANCH = 4;
  localparam int IX_LOAD   = 5;
  localparam int IX_STORE  = 6;
  localparam int IX_OP_IMM = 7;
  localparam int IX_OP     = 8;
  localparam logic [6:0] OPC_TABLE [OPC_NUM] = '{
    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
    OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP
  };

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_B    = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  localparam logic [1:0] PC_SRC_PC4 = 2'b00;
  localparam logic [1:0] PC_SRC_IMM = 2'b01;
  localparam logic [1:0] PC_SRC_ALU = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_BRANCH = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_JAL    = 3'd4,
    CLS_JALR   = 3'd5,
    CLS_NONE   = 3'd6
  } instr_class_t;

  typedef struct packed {
    instr_class_t cls;
    logic [2:0]   imm_type;
    logic         alu_src_a;
    logic         alu_src_b;
    logic [1:0]   wb_sel;
    logic         legal;
  } dec_t;

endpackage

// File: rtl/cpu_ctrl_fsm_opc_decode.sv
// Combinational opcode decoder: maps a 7-bit RV32I opcode to its class,
// immediate format, ALU operand selects and write-back source.
module cpu_ctrl_fsm_opc_decode
  import cpu_ctrl_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  output dec_t       dec
);

  logic [OPC_NUM-1:0] hit;

  for (genvar gi = 0; gi < OPC_NUM; gi++) begin : g_match
    assign hit[gi] = (opcode == OPC_TABLE[gi]);
  end

  always_comb begin
    dec.cls       = CLS_NONE;
    dec.imm_type  = IMM_NONE;
    dec.alu_src_a = 1'b0;
    dec.alu_src_b = 1'b0;
    dec.wb_sel    = WB_ALU;
    dec.legal     = |hit;
    case (1'b1)
      hit[IX_LUI]: begin
        dec.cls       = CLS_ALU;
        dec.imm_type  = IMM_U;
        dec.alu_src_b = 1'b1;
        dec.wb_sel    = WB_IMM;
      end
      hit[IX_AUIPC]: begin
        dec.cls       = CLS_ALU;
        dec.imm_type  = IMM_U;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
      end
      hit[IX_JAL]: begin
        dec.cls       = CLS_JAL;
        dec.imm_type  = IMM_J;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.wb_sel    = WB_PC4;
      end
      hit[IX_JALR]: begin
        dec.cls       = CLS_JALR;
        dec.imm_type  = IMM_I;
        dec.alu_src_b = 1'b1;
        dec.wb_sel    = WB_PC4;
      end
      hit[IX_BRANCH]: begin
        // ALU compares rs1 with rs2; the target uses the PC+imm path.
        dec.cls      = CLS_BRANCH;
        dec.imm_type = IMM_B;
      end
      hit[IX_LOAD]: begin
        dec.cls       = CLS_LOAD;
        dec.imm_type  = IMM_I;
        dec.alu_src_b = 1'b1;
        dec.wb_sel    = WB_MEM;
      end
      hit[IX_STORE]: begin
        dec.cls       = CLS_STORE;
        dec.imm_type  = IMM_S;
        dec.alu_src_b = 1'b1;
      end
      hit[IX_OP_IMM]: begin
        dec.cls       = CLS_ALU;
        dec.imm_type  = IMM_I;
        dec.alu_src_b = 1'b1;
      end
      hit[IX_OP]: begin
        dec.cls = CLS_ALU;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer (FETCH->DECODE->EXEC->MEM->WB) for a single-ALU datapath.
// Define CPU_ILLEGAL_TRAP_EN to trap undefined opcodes (TRAP state + illegal_instr); otherwise they retire as NOPs.
module cpu_ctrl_fsm
  import cpu_ctrl_fsm_pkg::*;
#(
  parameter int          XLEN   = 32,  // fixed at 32
  parameter int unsigned MEM_TO = 15   // 0 disables the MEM timeout flag
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] instr,
  output logic            instr_ready,
  input  logic            br_taken,
  input  logic            mem_ready,
  output logic [XLEN-1:0] ir,
  output logic [2:0]      imm_type,
  output logic            alu_src_a,
  output logic            alu_src_b,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic            mem_req,
  output logic            mem_we,
  output logic            reg_write,
  output logic [1:0]      wb_sel,
  output logic            mem_timeout,
`ifdef CPU_ILLEGAL_TRAP_EN
  output logic            illegal_instr,
`endif
  output logic [2:0]      state
);

  localparam int CNT_W = $clog2(MEM_TO + 2);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(MEM_TO);

  logic [2:0]      state_reg, state_next;
  logic [XLEN-1:0] ir_reg;
  dec_t            dec_reg, dec_in;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic            timeout_reg, timeout_set;
  logic            fetch_xfer;

  // Decoding the incoming word at the transfer edge gives the same result as
  // decoding ir, but makes the fields valid from the first DECODE cycle.
  cpu_ctrl_fsm_opc_decode u_decode (
    .opcode (instr[6:0]),
    .dec    (dec_in)
  );

  assign fetch_xfer = (state_reg == ST_FETCH) && instr_valid;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH:  if (instr_valid) state_next = ST_DECODE;
`ifdef CPU_ILLEGAL_TRAP_EN
      ST_DECODE: state_next = dec_reg.legal ? ST_EXEC : ST_TRAP;
`else
      ST_DECODE: state_next = ST_EXEC;
`endif
      ST_EXEC: begin
        if (!dec_reg.legal || dec_reg.cls == CLS_BRANCH)
          state_next = ST_FETCH;
        else if (dec_reg.cls == CLS_LOAD || dec_reg.cls == CLS_STORE)
          state_next = ST_MEM;
        else
          state_next = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready)
          state_next = (dec_reg.cls == CLS_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB:   state_next = ST_FETCH;
      ST_TRAP: state_next = ST_TRAP;
      default: state_next = ST_FETCH;
    endcase
  end

  // Counts consecutive un-acknowledged MEM cycles, saturating at the limit.
  always_comb begin
    wait_cnt_next = '0;
    timeout_set   = 1'b0;
    if (state_reg == ST_MEM && !mem_ready && TO_LIMIT != '0) begin
      wait_cnt_next = (wait_cnt_reg == TO_LIMIT) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
      timeout_set   = (wait_cnt_next == TO_LIMIT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_FETCH;
      ir_reg       <= NOP_INSTR;
      dec_reg      <= '0;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (fetch_xfer) begin
        ir_reg  <= instr;
        dec_reg <= dec_in;
      end
      if (timeout_set)
        timeout_reg <= 1'b1;
    end
  end

  always_comb begin
    instr_ready = (state_reg == ST_FETCH);
    mem_req     = (state_reg == ST_MEM);
    mem_we      = mem_req && (dec_reg.cls == CLS_STORE);
    pc_write    = 1'b0;
    pc_src      = PC_SRC_PC4;
    reg_write   = 1'b0;
    case (state_reg)
      ST_EXEC: begin
        if (!dec_reg.legal || dec_reg.cls == CLS_BRANCH) begin
          pc_write = 1'b1;
          if (dec_reg.cls == CLS_BRANCH && br_taken)
            pc_src = PC_SRC_IMM;
        end
      end
      ST_MEM: begin
        if (mem_ready && dec_reg.cls == CLS_STORE)
          pc_write = 1'b1;
      end
      ST_WB: begin
        pc_write  = 1'b1;
        reg_write = (ir_reg[11:7] != 5'd0);
        if (dec_reg.cls == CLS_JAL)
          pc_src = PC_SRC_IMM;
        else if (dec_reg.cls == CLS_JALR)
          pc_src = PC_SRC_ALU;
      end
      default: ;
    endcase
    // An instruction interrupted by reset must not commit any architectural state.
    if (rst) begin
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign ir          = ir_reg;
  assign imm_type    = dec_reg.imm_type;
  assign alu_src_a   = dec_reg.alu_src_a;
  assign alu_src_b   = dec_reg.alu_src_b;
  assign wb_sel      = dec_reg.wb_sel;
  assign mem_timeout = timeout_reg;
  assign state       = state_reg;

`ifdef CPU_ILLEGAL_TRAP_EN
  assign illegal_instr = (state_reg == ST_TRAP);
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: directed spec cases plus randomized
// instruction streams checked against a latency/strobe reference model.
module tb_cpu_ctrl_fsm;

  localparam int TB_MEM_TO = 2;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        br_taken;
  logic        mem_ready;
  logic [31:0] ir;
  logic [2:0]  imm_type;
  logic        alu_src_a;
  logic        alu_src_b;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        mem_req;
  logic        mem_we;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        mem_timeout;
  logic [2:0]  state;
`ifdef CPU_ILLEGAL_TRAP_EN
  logic        illegal_instr;
`endif

  cpu_ctrl_fsm #(.XLEN(32), .MEM_TO(TB_MEM_TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .br_taken    (br_taken),
    .mem_ready   (mem_ready),
    .ir          (ir),
    .imm_type    (imm_type),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .reg_write   (reg_write),
    .wb_sel      (wb_sel),
    .mem_timeout (mem_timeout),
`ifdef CPU_ILLEGAL_TRAP_EN
    .illegal_instr (illegal_instr),
`endif
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          lat;
    logic [1:0]  pc_src;
    logic        rw;
    logic        check_wb;
    logic [1:0]  wb_sel;
    logic [2:0]  imm;
    logic        a;
    logic        b;
    int          mem_cyc;
    logic        mem_we;
    logic        tout;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   n_txn = 0;
  int   cur_wait = 0;
  logic tout_model = 1'b0;
  logic [6:0] opc_tab [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
  logic [6:0] ill_tab [4] = '{7'h7F, 7'h00, 7'h0F, 7'h73};

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  task automatic abort(input string what);
    n_vec++;
    n_miss++;
    $display("FAIL %s: wait bound expired, got no progress, expected completion", what);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  endtask

  // Reference behaviour: per-opcode strobes and cycle counts from the instruction-set rules.
  function automatic exp_t model(input logic [31:0] ins, input logic br, input int w);
    exp_t e;
    bit   writes;
    writes = 0;
    e.instr = ins; e.lat = 3; e.pc_src = 2'b00; e.rw = 0; e.check_wb = 0; e.wb_sel = 2'b00;
    e.imm = 3'b111; e.a = 0; e.b = 0; e.mem_cyc = 0; e.mem_we = 0; e.tout = 0;
    case (ins[6:0])
      7'b0110111: begin e.imm = 3'b011; e.b = 1; e.wb_sel = 2'b11; writes = 1; end
      7'b0010111: begin e.imm = 3'b011; e.a = 1; e.b = 1; writes = 1; end
      7'b1101111: begin e.imm = 3'b100; e.a = 1; e.b = 1; e.wb_sel = 2'b10; e.pc_src = 2'b01; writes = 1; end
      7'b1100111: begin e.imm = 3'b000; e.b = 1; e.wb_sel = 2'b10; e.pc_src = 2'b10; writes = 1; end
      7'b1100011: begin e.imm = 3'b001; e.pc_src = br ? 2'b01 : 2'b00; end
      7'b0000011: begin e.imm = 3'b000; e.b = 1; e.wb_sel = 2'b01; e.mem_cyc = w + 1; writes = 1; end
      7'b0100011: begin e.imm = 3'b010; e.b = 1; e.mem_cyc = w + 1; e.mem_we = 1; e.lat = 4 + w; end
      7'b0010011: begin e.imm = 3'b000; e.b = 1; writes = 1; end
      7'b0110011: writes = 1;
      default: ;
    endcase
    if (writes) begin
      e.lat = (e.mem_cyc > 0) ? 5 + w : 4;
      e.rw = (ins[11:7] != 5'd0);
      e.check_wb = 1;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch();
    int g = 0;
    while (!instr_ready) begin
      step();
      g++;
      if (g > 100) begin abort("wait_fetch"); return; end
    end
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 || !instr_ready) begin
      step();
      g++;
      if (g > 200) begin abort("drain"); return; end
    end
  endtask

  task automatic issue(input logic [31:0] ins, input logic br, input int w);
    exp_t e;
    wait_fetch();
    repeat ($urandom_range(0, 2)) begin
      instr = $urandom;
      step();
    end
    br_taken = br;
    cur_wait = w;
    e = model(ins, br, w);
    if (e.mem_cyc > 0 && TB_MEM_TO != 0 && w >= TB_MEM_TO) tout_model = 1'b1;
    e.tout = tout_model;
    sb.push_back(e);
    instr_valid = 1'b1;
    instr = ins;
    step();
    instr_valid = 1'b0;
    instr = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tout_model = 1'b0;
    chk("rst_state", 32'(state), 0);
    chk("rst_ir", ir, 32'h0000_0013);
    chk("rst_mem_timeout", 32'(mem_timeout), 0);
    chk("rst_instr_ready", 32'(instr_ready), 1);
  endtask

  // Memory responder: acknowledges after cur_wait cycles of mem_req.
  initial begin : responder
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    forever begin
      step();
      if (rst || !mem_req) begin
        cnt = 0;
        mem_ready = 1'b0;
      end else if (cnt >= cur_wait) begin
        mem_ready = 1'b1;
        cnt = 0;
      end else begin
        mem_ready = 1'b0;
        cnt++;
      end
    end
  end

  // Monitor: times each instruction from its fetch transfer to its PC update.
  initial begin : monitor
    bit   busy;
    int   cyc;
    int   mcyc;
    logic we_seen;
    exp_t e;
    busy = 0; cyc = 0; mcyc = 0; we_seen = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0;
        continue;
      end
      if (busy) begin
        cyc++;
        if (mem_req) begin
          mcyc++;
          we_seen = mem_we;
        end
        if (!pc_write) begin
          chk("early_reg_write", 32'(reg_write), 0);
        end else begin
          busy = 0;
          if (sb.size() == 0) begin
            chk("scoreboard_depth", 0, 1);
          end else begin
            e = sb.pop_front();
            chk("ir", ir, e.instr);
            chk("latency", 32'(cyc), 32'(e.lat));
            chk("pc_src", 32'(pc_src), 32'(e.pc_src));
            chk("reg_write", 32'(reg_write), 32'(e.rw));
            if (e.check_wb) chk("wb_sel", 32'(wb_sel), 32'(e.wb_sel));
            chk("imm_type", 32'(imm_type), 32'(e.imm));
            chk("alu_src_a", 32'(alu_src_a), 32'(e.a));
            chk("alu_src_b", 32'(alu_src_b), 32'(e.b));
            chk("mem_cycles", 32'(mcyc), 32'(e.mem_cyc));
            if (e.mem_cyc > 0) chk("mem_we", 32'(we_seen), 32'(e.mem_we));
            chk("mem_timeout", 32'(mem_timeout), 32'(e.tout));
            n_txn++;
            $display("txn %0d ir=%08h lat=%0d pc_src=%0d reg_write=%0d mem_cyc=%0d timeout=%0d",
                     n_txn, ir, cyc, pc_src, reg_write, mcyc, mem_timeout);
          end
        end
      end else begin
        chk("idle_strobes", {30'd0, pc_write, reg_write}, 0);
        if (instr_valid && instr_ready) begin
          busy = 1; cyc = 1; mcyc = 0; we_seen = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    abort("watchdog");
  end

  initial begin : driver
    logic [31:0] ins;
    int          sel;
    int          g;
    rst = 1'b1; instr_valid = 1'b0; instr = 32'h0; br_taken = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_state", 32'(state), 0);
    chk("rst_ir", ir, 32'h0000_0013);
    chk("rst_imm_type", 32'(imm_type), 0);
    chk("rst_alu_src", {30'd0, alu_src_a, alu_src_b}, 0);
    chk("rst_pc_write", 32'(pc_write), 0);
    chk("rst_pc_src", 32'(pc_src), 0);
    chk("rst_reg_write", 32'(reg_write), 0);
    chk("rst_wb_sel", 32'(wb_sel), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_timeout", 32'(mem_timeout), 0);
    chk("rst_instr_ready", 32'(instr_ready), 1);

    issue(32'h0050_0093, 1'b0, 0);   // ADDI x1,x0,5
    issue(32'h0000_0463, 1'b1, 0);   // BEQ taken
    issue(32'h0000_0463, 1'b0, 0);   // BEQ not taken
    issue(32'h0011_2023, 1'b0, 3);   // SW, three wait cycles
    issue(32'h0000_2083, 1'b0, 5);   // LW, exceeds the wait limit
    issue(32'h0080_00EF, 1'b0, 0);   // JAL x1
    issue(32'h1234_5037, 1'b0, 0);   // LUI x0: no register write
`ifndef CPU_ILLEGAL_TRAP_EN
    issue(32'h0000_007F, 1'b0, 0);   // undefined opcode retires as NOP
`endif
    drain();
    do_reset();

    for (int t = 0; t < 160; t++) begin
      if (t % 40 == 39) begin
        drain();
        do_reset();
      end
`ifdef CPU_ILLEGAL_TRAP_EN
      sel = $urandom_range(0, 8);
`else
      sel = $urandom_range(0, 9);
`endif
      ins = $urandom;
      if (sel < 9) ins[6:0] = opc_tab[sel];
      else         ins[6:0] = ill_tab[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
      issue(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end
    drain();

    // Reset while a store waits in MEM.
    cur_wait = 1000;
    br_taken = 1'b0;
    instr_valid = 1'b1;
    instr = 32'h0011_2023;
    step();
    instr_valid = 1'b0;
    g = 0;
    while (!mem_req) begin
      step();
      g++;
      if (g > 20) begin abort("reach_mem"); break; end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("timeout_before_rst", 32'(mem_timeout), 1);
    rst = 1'b1;
    #1;
    chk("rst_cycle_pc_write", 32'(pc_write), 0);
    chk("rst_cycle_reg_write", 32'(reg_write), 0);
    chk("rst_cycle_mem_req", 32'(mem_req), 1);
    step();
    rst = 1'b0;
    tout_model = 1'b0;
    chk("post_rst_state", 32'(state), 0);
    chk("post_rst_mem_req", 32'(mem_req), 0);
    chk("post_rst_mem_timeout", 32'(mem_timeout), 0);

`ifdef CPU_ILLEGAL_TRAP_EN
    wait_fetch();
    instr_valid = 1'b1;
    instr = 32'h0000_007F;
    step();
    instr_valid = 1'b0;
    repeat (4) step();
    chk("trap_state", 32'(state), 5);
    chk("trap_illegal_instr", 32'(illegal_instr), 1);
    chk("trap_strobes", {28'd0, pc_write, reg_write, mem_req, instr_ready}, 0);
    do_reset();
    chk("trap_cleared", 32'(illegal_instr), 0);
`endif

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
